// File: rtl/axil_mem_master_pkg.sv
// Shared FSM state encoding and AXI response codes for the AXI-lite memory master.
package axil_mem_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    ERR
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_mem_master.sv
// Single-outstanding request-to-AXI-lite master: one read or write per request, 3-cycle minimum latency.
// Requests are stalled (req_ready=0) until the current transaction's response pulse.
module axil_mem_master
  import axil_mem_master_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = 32'h8000_0000,
  parameter logic [31:0] ADDR_HI = 32'h87FF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wen;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_resp_vld;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic w_accept;
  logic w_in_range;
  logic w_resp_hs;

  assign w_in_range = (req_addr >= ADDR_LO) && (req_addr <= ADDR_HI);
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_resp_hs  = (rready && rvalid) || (bready && bvalid);

  assign araddr     = r_addr;
  assign awaddr     = r_addr;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign resp_valid = r_resp_vld;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // All AXI valids/readies decode from registered state only.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!w_in_range) w_next = ERR;
          else if (req_wen) w_next = WR_REQ;
          else w_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) w_next = IDLE;
      end
      WR_REQ: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = IDLE;
      end
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wen     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_accept) begin
      r_addr    <= req_addr;
      r_wdata   <= req_wdata;
      r_wstrb   <= req_wstrb;
      r_wen     <= req_wen;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;
    end
  end

  // Out-of-range requests answer during the ERR cycle itself; writes leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_vld   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_vld <= 1'b0;
      if (w_accept && !w_in_range) begin
        r_resp_vld   <= 1'b1;
        r_resp_err   <= 1'b1;
        r_resp_rdata <= '0;
      end else if (w_resp_hs) begin
        r_resp_vld <= 1'b1;
        r_resp_err <= r_wen ? (bresp != OKAY) : (rresp != OKAY);
        if (!r_wen) r_resp_rdata <= rdata;
      end
    end
  end

endmodule
